// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module : ctrl_pkg
// Brief  : Shared opcodes, immediate/PC-select encodings and enums for the
//          RV32I multi-cycle controller and its datapath neighbours.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate formats, must match the immediate generator's select decode.
  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_TARGET = 2'b01;
  localparam logic [1:0] PCSEL_JALR   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LUI    = 3'd1,
    CLS_AUIPC  = 3'd2,
    CLS_JAL    = 3'd3,
    CLS_JALR   = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_LOAD   = 3'd6,
    CLS_STORE  = 3'd7
  } iclass_t;

endpackage

`default_nettype wire

// File: rtl/instr_class_dec.sv
// ============================================================================
// Module : instr_class_dec
// Brief  : Combinational opcode decode to instruction class, immediate format
//          and legality flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_class_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_t    o_cls,
  output logic [2:0] o_extop,
  output logic       o_legal
);

  always_comb begin
    o_cls   = CLS_ALU;
    o_extop = EXT_I;
    o_legal = 1'b1;
    case (i_opcode)
      OPC_OP_IMM: begin o_cls = CLS_ALU;    o_extop = EXT_I; end
      OPC_OP:     begin o_cls = CLS_ALU;    o_extop = EXT_I; end
      OPC_LOAD:   begin o_cls = CLS_LOAD;   o_extop = EXT_I; end
      OPC_JALR:   begin o_cls = CLS_JALR;   o_extop = EXT_I; end
      OPC_LUI:    begin o_cls = CLS_LUI;    o_extop = EXT_U; end
      OPC_AUIPC:  begin o_cls = CLS_AUIPC;  o_extop = EXT_U; end
      OPC_STORE:  begin o_cls = CLS_STORE;  o_extop = EXT_S; end
      OPC_BRANCH: begin o_cls = CLS_BRANCH; o_extop = EXT_B; end
      OPC_JAL:    begin o_cls = CLS_JAL;    o_extop = EXT_J; end
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : RV32I multi-cycle control FSM: IDLE -> DECODE -> EXEC -> MEM -> WB.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  output logic [2:0]  extop,
  output logic        alu_en,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        reg_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [7:0] c_mem_timeout = 8'(MEM_TIMEOUT);

  state_t      r_state;
  iclass_t     r_cls;
  logic [31:0] r_ir;
  logic [2:0]  r_extop;
  logic [7:0]  r_wait_cnt;

  iclass_t     w_cls;
  logic [2:0]  w_extop;
  logic        w_legal;
  logic        w_timeout;
  logic        w_mem_done;
  logic        w_br_retire;
  logic        w_st_retire;

  instr_class_dec u_dec (
    .i_opcode (r_ir[6:0]),
    .o_cls    (w_cls),
    .o_extop  (w_extop),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cls      <= CLS_ALU;
      r_ir       <= 32'd0;
      r_extop    <= EXT_I;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_cls   <= w_cls;
            r_extop <= w_extop;
            r_state <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_wait_cnt <= 8'd0;
          case (r_cls)
            CLS_BRANCH:          r_state <= ST_IDLE;
            CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
            default:             r_state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          // The timeout cycle has mem_req already dropped, so a late ack there is ignored.
          if (w_timeout) begin
            r_state <= ST_IDLE;
          end else if (mem_ack) begin
            r_state <= (r_cls == CLS_LOAD) ? ST_WB : ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_timeout   = (r_state == ST_MEM) && (r_wait_cnt == c_mem_timeout);
  assign w_mem_done  = mem_req && mem_ack;
  assign w_br_retire = (r_state == ST_EXEC) && (r_cls == CLS_BRANCH);
  assign w_st_retire = w_mem_done && (r_cls == CLS_STORE);

  assign ir          = r_ir;
  assign extop       = r_extop;
  assign instr_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign alu_en      = (r_state == ST_EXEC);
  assign mem_req     = (r_state == ST_MEM) && !w_timeout;
  assign mem_we      = mem_req && (r_cls == CLS_STORE);
  assign reg_we      = (r_state == ST_WB);
  assign pc_we       = reg_we || w_br_retire || w_st_retire;
  assign retire      = pc_we;
  assign illegal     = (r_state == ST_DECODE) && !w_legal;
  assign bus_err     = w_timeout;

  always_comb begin
    pc_sel = PCSEL_PLUS4;
    if (r_state == ST_WB) begin
      if (r_cls == CLS_JAL)       pc_sel = PCSEL_TARGET;
      else if (r_cls == CLS_JALR) pc_sel = PCSEL_JALR;
    end else if (w_br_retire && br_taken) begin
      pc_sel = PCSEL_TARGET;
    end
  end

endmodule

`default_nettype wire
